// File: rtl/decoder.sv
// rtl/decoder.sv - binary-to-one-hot decoder with registered stage and optional usage statistics (DECODER_STATS_EN)
module decoder #(
  parameter  int IN_W  = 2,
  localparam int OUT_W = 2 ** IN_W,
  parameter  int CNT_W = 8
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [OUT_W-1:0] out_q,
  output logic             valid_q,
  output logic [OUT_W-1:0] seen,
  input  logic [IN_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt
);

  // One-hot decode of the input code; independent of clock, reset and strobes
  always_comb begin
    out     = '0;
    out[in] = 1'b1;
  end

  // Registered copy of the decode, loaded on en; valid_q marks a fresh load
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      out_q   <= out;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

`ifdef DECODER_STATS_EN
  logic [CNT_W-1:0] hits [OUT_W];

  // Sticky seen mask and saturating per-code hit counters; clr discards a same-edge capture
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seen <= '0;
      for (int k = 0; k < OUT_W; k++) begin
        hits[k] <= '0;
      end
    end else if (en) begin
      seen <= seen | out;
      for (int k = 0; k < OUT_W; k++) begin
        if (out[k] && (hits[k] != {CNT_W{1'b1}})) begin
          hits[k] <= hits[k] + 1'b1;
        end
      end
    end
  end

  // Counter readback shows registered state only, no same-edge bypass
  always_comb begin
    cnt = hits[cnt_sel];
  end
`else
  logic unused_stats_inputs;

  // Statistics not built: outputs tied off, clr and cnt_sel ignored
  always_comb begin
    seen                = '0;
    cnt                 = '0;
    unused_stats_inputs = clr ^ (^cnt_sel);
  end
`endif

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - directed self-checking bench for decoder
module tb_decoder;

`ifdef DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] in;
  logic [1:0] cnt_sel;
  logic [3:0] out;
  logic [3:0] out_q;
  logic       valid_q;
  logic [3:0] seen;
  logic [7:0] cnt;

  int checks   = 0;
  int failures = 0;

  decoder dut (
    .in      (in),
    .out     (out),
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .out_q   (out_q),
    .valid_q (valid_q),
    .seen    (seen),
    .cnt_sel (cnt_sel),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    cnt_sel = sel;
    #1;
    check(tag, {24'd0, cnt}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; in = 2'd0; cnt_sel = 2'd0;

    // combinational sweep under reset
    #1 check("out_in0", {28'd0, out}, 32'b0001);
    in = 2'd1; #1 check("out_in1", {28'd0, out}, 32'b0010);
    in = 2'd2; #1 check("out_in2", {28'd0, out}, 32'b0100);
    in = 2'd3; #1 check("out_in3", {28'd0, out}, 32'b1000);

    // reset state
    tick(); tick();
    check("rst_out_q", {28'd0, out_q}, 32'd0);
    check("rst_valid", {31'd0, valid_q}, 32'd0);
    check("rst_seen", {28'd0, seen}, 32'd0);
    check_cnt("rst_cnt0", 2'd0, 8'd0);
    check_cnt("rst_cnt3", 2'd3, 8'd0);

    // single capture then hold
    rst = 1'b0; en = 1'b1; in = 2'd2;
    tick();
    check("cap_out_q", {28'd0, out_q}, 32'b0100);
    check("cap_valid", {31'd0, valid_q}, 32'd1);
    check("cap_seen", {28'd0, seen}, STATS ? 32'b0100 : 32'd0);
    check_cnt("cap_cnt2", 2'd2, STATS ? 8'd1 : 8'd0);
    en = 1'b0; in = 2'd1;
    tick();
    check("hold_out_q", {28'd0, out_q}, 32'b0100);
    check("hold_valid", {31'd0, valid_q}, 32'd0);

    // reset, then codes 1,1,3
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_seen", {28'd0, seen}, 32'd0);
    en = 1'b1; in = 2'd1; tick();
    in = 2'd1; tick();
    in = 2'd3; tick();
    en = 1'b0;
    check("seq_out_q", {28'd0, out_q}, 32'b1000);
    check("seq_seen", {28'd0, seen}, STATS ? 32'b1010 : 32'd0);
    check_cnt("seq_cnt1", 2'd1, STATS ? 8'd2 : 8'd0);
    check_cnt("seq_cnt3", 2'd3, STATS ? 8'd1 : 8'd0);
    check_cnt("seq_cnt0", 2'd0, 8'd0);

    // reset mid-stream beats en; out keeps following in
    rst = 1'b1; en = 1'b1; in = 2'd0;
    tick();
    check("midrst_out_q", {28'd0, out_q}, 32'd0);
    check("midrst_valid", {31'd0, valid_q}, 32'd0);
    check("midrst_seen", {28'd0, seen}, 32'd0);
    in = 2'd3; #1 check("midrst_out", {28'd0, out}, 32'b1000);
    rst = 1'b0; en = 1'b0;
    tick();

    // saturation of counter 0
    en = 1'b1; in = 2'd0;
    for (int i = 0; i < 254; i++) tick();
    check_cnt("sat_cnt0_254", 2'd0, STATS ? 8'd254 : 8'd0);
    tick();
    check_cnt("sat_cnt0_255", 2'd0, STATS ? 8'd255 : 8'd0);
    for (int i = 0; i < 45; i++) tick();
    check_cnt("sat_cnt0_hold", 2'd0, STATS ? 8'd255 : 8'd0);
    check("sat_out_q", {28'd0, out_q}, 32'b0001);
    check("sat_seen", {28'd0, seen}, STATS ? 32'b0001 : 32'd0);

    // clr with en on the same edge
    clr = 1'b1; en = 1'b1; in = 2'd2;
    tick();
    clr = 1'b0; en = 1'b0;
    check("clr_out_q", {28'd0, out_q}, 32'b0100);
    check("clr_valid", {31'd0, valid_q}, 32'd1);
    check("clr_seen", {28'd0, seen}, 32'd0);
    check_cnt("clr_cnt0", 2'd0, 8'd0);
    check_cnt("clr_cnt2", 2'd2, 8'd0);
    tick();
    check("post_clr_valid", {31'd0, valid_q}, 32'd0);
    check("post_clr_out_q", {28'd0, out_q}, 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
